av2_deblocking_filter_real: RTL and testbench

- Frame-level AV2 in-loop deblocking filter for 10-bit luma.
- Takes a whole frame (up to MAX_WIDTH x MAX_HEIGHT) on array ports and applies an AV1-style narrow (filter4) deblock on every 8-pixel block edge.
- Processes vertical edges first, then horizontal edges, and presents the result with a valid/ready handshake.
- Sits after reconstruction and ahead of CDEF/loop-restoration in the decoder pipeline.

---
 rtl/av2_deblocking_filter_real.sv | 182 ++++++++++++++++++
 tb/tb_av2_deblocking_filter_real.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/av2_deblocking_filter_real.sv
// av2_deblocking_filter_real: frame-level AV2 narrow (filter4) deblocking for 10-bit luma.
// Optional edge counter output enabled by defining AV2_DBF_EDGE_COUNT_EN.
module av2_deblocking_filter_real #(
    parameter int MAX_WIDTH  = 128,
    parameter int MAX_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  src_pixels [0:MAX_WIDTH*MAX_HEIGHT-1],
    input  logic [15:0] frame_width,
    input  logic [15:0] frame_height,
    input  logic [5:0]  filter_level,
    input  logic [2:0]  sharpness,
    input  logic        start,
    output logic [9:0]  dst_pixels [0:MAX_WIDTH*MAX_HEIGHT-1],
    output logic        valid,
    input  logic        ready
`ifdef AV2_DBF_EDGE_COUNT_EN
    ,
    output logic [15:0] edges_filtered
`endif
);
    localparam int NPIX = MAX_WIDTH * MAX_HEIGHT;
    localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, VPASS, HPASS, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] w_q, h_q, line_q, line_d, pos_q, pos_d;
    logic [5:0]  level_q;
    logic [11:0] lim4_q, blim4_q, thr4_q, lim4_d, blim4_d, thr4_d;
    logic [9:0]  buf_q [0:NPIX-1];

    logic        vert, pass, last_edge, last_line, mask, hev;
    logic [31:0] base, stride;
    logic [AW-1:0] i_p1, i_p0, i_q0, i_q1;
    logic [9:0]  np1, np0, nq0, nq1;
    int          shift, lim, p1, p0, q0, q1, f, f1, f2, a, lim4, blim4, thr4;

    function automatic int clamp(input int v);
        return (v < -512) ? -512 : (v > 511) ? 511 : v;
    endfunction

    function automatic int absd(input int x, input int y);
        return (x > y) ? x - y : y - x;
    endfunction

    assign dst_pixels = buf_q;

    // Filter thresholds derived from the requested level and sharpness, scaled for 10-bit
    always_comb begin
        shift = (sharpness > 3'd4) ? 2 : (sharpness > 3'd0) ? 1 : 0;
        lim = int'(filter_level) >>> shift;
        lim = (sharpness != 3'd0 && lim > 9 - int'(sharpness)) ? 9 - int'(sharpness) : lim;
        lim = (lim < 1) ? 1 : lim;
        lim4_d = 12'(lim << 2);
        blim4_d = 12'((2 * (int'(filter_level) + 2) + lim) << 2);
        thr4_d = 12'((int'(filter_level) >>> 4) << 2);
    end

    // Edge walker: pos steps along edges (8, 16, ...), line steps across the perpendicular axis
    always_comb begin
        vert = state_q == VPASS;
        pass = state_q == VPASS || state_q == HPASS;
        last_edge = 32'(pos_q) + 32'd8 >= 32'(vert ? w_q : h_q);
        last_line = 32'(line_q) + 32'd1 >= 32'(vert ? h_q : w_q);
        pos_d = (pass && !last_edge) ? pos_q + 16'd8 : 16'd8;
        line_d = !pass ? 16'd0 : !last_edge ? line_q : last_line ? 16'd0 : line_q + 16'd1;
        base = vert ? 32'(line_q) * 32'(w_q) + 32'(pos_q) - 32'd2
                    : (32'(pos_q) - 32'd2) * 32'(w_q) + 32'(line_q);
        stride = vert ? 32'd1 : 32'(w_q);
        i_p1 = AW'(base);
        i_p0 = AW'(base + stride);
        i_q0 = AW'(base + 2 * stride);
        i_q1 = AW'(base + 3 * stride);
    end

    // Mask, high-edge-variance and filter4 arithmetic on the current four-tap segment
    always_comb begin
        lim4 = int'(lim4_q);
        blim4 = int'(blim4_q);
        thr4 = int'(thr4_q);
        p1 = int'(buf_q[i_p1]);
        p0 = int'(buf_q[i_p0]);
        q0 = int'(buf_q[i_q0]);
        q1 = int'(buf_q[i_q1]);
        mask = absd(p1, p0) <= lim4 && absd(q1, q0) <= lim4 &&
               2 * absd(p0, q0) + (absd(p1, q1) >>> 1) <= blim4;
        hev = absd(p1, p0) > thr4 || absd(q1, q0) > thr4;
        f = hev ? clamp(p1 - q1) : 0;
        f = clamp(f + 3 * (q0 - p0));
        f1 = clamp(f + 4) >>> 3;
        f2 = clamp(f + 3) >>> 3;
        a = (f1 + 1) >>> 1;
        nq0 = 10'(clamp(q0 - 512 - f1) + 512);
        np0 = 10'(clamp(p0 - 512 + f2) + 512);
        nq1 = hev ? buf_q[i_q1] : 10'(clamp(q1 - 512 - a) + 512);
        np1 = hev ? buf_q[i_p1] : 10'(clamp(p1 - 512 + a) + 512);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; passes without interior edges are skipped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = start ? LOAD : IDLE;
            LOAD:  state_d = (level_q == 6'd0 || (w_q < 16'd9 && h_q < 16'd9)) ? DONE :
                             (w_q >= 16'd9) ? VPASS : HPASS;
            VPASS: state_d = !(last_edge && last_line) ? VPASS : (h_q >= 16'd9) ? HPASS : DONE;
            HPASS: state_d = (last_edge && last_line) ? DONE : HPASS;
            DONE:  state_d = ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        valid = state_q == DONE;
    end

    // Frame parameters and thresholds captured on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            h_q <= '0;
            level_q <= '0;
            lim4_q <= '0;
            blim4_q <= '0;
            thr4_q <= '0;
        end else if (state_q == IDLE && start) begin
            w_q <= (frame_width > 16'(MAX_WIDTH)) ? 16'(MAX_WIDTH) : frame_width;
            h_q <= (frame_height > 16'(MAX_HEIGHT)) ? 16'(MAX_HEIGHT) : frame_height;
            level_q <= filter_level;
            lim4_q <= lim4_d;
            blim4_q <= blim4_d;
            thr4_q <= thr4_d;
        end
    end

    // Edge walker position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= 16'd8;
            line_q <= '0;
        end else begin
            pos_q <= pos_d;
            line_q <= line_d;
        end
    end

    // Working buffer: loaded from the source frame, then updated in place one segment per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '{default: '0};
        end else if (state_q == LOAD) begin
            buf_q <= src_pixels;
        end else if (pass && mask) begin
            buf_q[i_p1] <= np1;
            buf_q[i_p0] <= np0;
            buf_q[i_q0] <= nq0;
            buf_q[i_q1] <= nq1;
        end
    end

`ifdef AV2_DBF_EDGE_COUNT_EN
    logic [15:0] cnt_q;

    // Saturating count of segments whose mask passed in the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  cnt_q <= '0;
        else if (state_q == LOAD)                    cnt_q <= '0;
        else if (pass && mask && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
    end

    assign edges_filtered = cnt_q;
`endif
endmodule

// File: tb/tb_av2_deblocking_filter_real.sv
// tb_av2_deblocking_filter_real: directed checks of bypass, filtering, masking, handshake and reset.
module tb_av2_deblocking_filter_real;
    localparam int N = 128 * 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  src [0:N-1];
    logic [9:0]  dst [0:N-1];
    logic [15:0] fw = 16'd64, fh = 16'd64;
    logic [5:0]  lvl = '0;
    logic [2:0]  shp = '0;
    logic        start = 1'b0, ready = 1'b0, valid;
`ifdef AV2_DBF_EDGE_COUNT_EN
    logic [15:0] edges;
`endif
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    av2_deblocking_filter_real dut (
        .clk(clk), .rst_n(rst_n), .src_pixels(src),
        .frame_width(fw), .frame_height(fh), .filter_level(lvl), .sharpness(shp),
        .start(start), .dst_pixels(dst), .valid(valid), .ready(ready)
`ifdef AV2_DBF_EDGE_COUNT_EN
        , .edges_filtered(edges)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_flat(input logic [9:0] v);
        for (int i = 0; i < N; i++) src[i] = v;
    endtask

    task automatic fill_runs();
        fill_flat(10'd128);
        for (int i = 0; i < 64; i++) src[i] = 10'((i / 8) * 32);
    endtask

    task automatic run(input int w, input int h, input int l, input int s, output int lat);
        fw = 16'(w);
        fh = 16'(h);
        lvl = 6'(l);
        shp = 3'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 3000) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++;
        if (dst[0] !== 10'd0 || dst[5000] !== 10'd0 || dst[N-1] !== 10'd0) begin
            errors++;
            $display("FAIL reset_dst got %0d/%0d/%0d want 0/0/0", dst[0], dst[5000], dst[N-1]);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        int lat, bad;
        fill_flat(10'd128);
        ready = 1'b0;
        run(64, 64, 0, 0, lat);
        vectors++;
        if (lat !== 2) begin errors++; $display("FAIL bypass_latency got %0d want 2", lat); end
        bad = 0;
        for (int i = 0; i < N; i++) if (dst[i] !== 10'd128) bad++;
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL bypass_pixels got %0d differing want 0", bad); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin errors++; $display("FAIL bypass_release got %b want 0", valid); end
    endtask

    task automatic test_light();
        localparam int IX [12] = '{6, 7, 8, 9, 14, 15, 16, 17, 0, 3, 64, 100};
        localparam int EX [12] = '{6, 12, 20, 26, 38, 44, 52, 58, 0, 0, 128, 128};
        int lat;
        fill_runs();
        run(64, 64, 10, 0, lat);
        vectors++;
        if (lat !== 898) begin errors++; $display("FAIL light_latency got %0d want 898", lat); end
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (dst[IX[k]] !== 10'(EX[k])) begin
                errors++;
                $display("FAIL light_px%0d got %0d want %0d", IX[k], dst[IX[k]], EX[k]);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_small_frame();
        localparam int IX [11] = '{6, 7, 8, 9, 22, 23, 24, 25, 60, 256, 300};
        localparam int EX [11] = '{6, 12, 20, 26, 70, 76, 84, 90, 224, 128, 128};
        int lat;
        fill_runs();
        run(16, 16, 20, 1, lat);
        vectors++;
        if (lat !== 34) begin errors++; $display("FAIL small_latency got %0d want 34", lat); end
        for (int k = 0; k < 11; k++) begin
            vectors++;
            if (dst[IX[k]] !== 10'(EX[k])) begin
                errors++;
                $display("FAIL small_px%0d got %0d want %0d", IX[k], dst[IX[k]], EX[k]);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_mask_reject();
        int lat, bad;
        fill_flat(10'd128);
        for (int i = 0; i < 4096; i++) src[i] = (i % 64 < 8) ? 10'd0 : 10'd512;
        run(64, 64, 1, 0, lat);
        vectors++;
        if (lat !== 898) begin errors++; $display("FAIL mask_latency got %0d want 898", lat); end
        bad = 0;
        for (int i = 0; i < N; i++) if (dst[i] !== src[i]) bad++;
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL mask_pixels got %0d changed want 0", bad); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_handshake();
        int lat, drops, moved, late;
        logic [9:0] d7;
        fill_runs();
        ready = 1'b0;
        run(16, 16, 20, 1, lat);
        vectors++;
        if (valid !== 1'b1) begin errors++; $display("FAIL hs_valid got %b want 1", valid); end
        d7 = dst[7];
        drops = 0;
        moved = 0;
        for (int c = 0; c < 10; c++) begin
            lvl = 6'd0;
            start = (c == 4);
            tick();
            if (valid !== 1'b1) drops++;
            if (dst[7] !== d7) moved++;
        end
        start = 1'b0;
        vectors++;
        if (drops != 0) begin errors++; $display("FAIL hs_hold got %0d drops want 0", drops); end
        vectors++;
        if (moved != 0 || d7 !== 10'd12) begin
            errors++;
            $display("FAIL hs_stable got %0d changes px7 %0d want 0 changes px7 12", moved, d7);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin errors++; $display("FAIL hs_accept got %b want 0", valid); end
        late = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (valid !== 1'b0) late++;
        end
        vectors++;
        if (late != 0) begin errors++; $display("FAIL hs_start_ignored got %0d valid cycles want 0", late); end
    endtask

    task automatic test_back_to_back();
        int lat;
        fill_flat(10'd200);
        ready = 1'b1;
        run(16, 16, 0, 0, lat);
        vectors++;
        if (lat !== 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", lat); end
        tick();
        vectors++;
        if (valid !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle got %b want 0", valid); end
        vectors++;
        if (dst[17] !== 10'd200) begin errors++; $display("FAIL b2b_pixel got %0d want 200", dst[17]); end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int late;
        fill_runs();
        fw = 16'd64;
        fh = 16'd64;
        lvl = 6'd10;
        shp = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid); end
        vectors++;
        if (dst[6] !== 10'd0 || dst[100] !== 10'd0) begin
            errors++;
            $display("FAIL midrst_dst got %0d/%0d want 0/0", dst[6], dst[100]);
        end
        tick();
        rst_n = 1'b1;
        late = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid !== 1'b0) late++;
        end
        vectors++;
        if (late != 0) begin errors++; $display("FAIL midrst_idle got %0d valid cycles want 0", late); end
    endtask

    initial begin
        fill_flat(10'd0);
        test_reset();
        test_bypass();
        test_light();
        test_small_frame();
        test_mask_reject();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
